i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 105 ++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : I2S transmitter with fixed 32-slot half-frames derived from a
//            100 MHz clock; one-deep sample-pair holding register.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
   parameter int WIDTH = 24
) (
   input  logic             clk100,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_l,
   input  logic [WIDTH-1:0] din_r,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             underrun,
   output logic             frame_tick,
   output logic             mclk,
   output logic             sclk,
   output logic             lrck,
   output logic             sdata
);
   localparam logic [4:0] LAST_SLOT = 5'(WIDTH);

   logic [10:0]      cnt;
   logic             hold_full;
   logic [WIDTH-1:0] hold_l;
   logic [WIDTH-1:0] hold_r;
   logic [WIDTH-1:0] shift_l;
   logic [WIDTH-1:0] shift_r;

   logic [4:0] slot;
   logic       frame_start;
   logic       slot_start;
   logic       data_slot;
   logic       accept;

   // Frame start is the cycle in which cnt is about to wrap to 0.
   assign slot        = cnt[9:5];
   assign frame_start = (cnt == 11'd2047);
   assign slot_start  = (cnt[4:0] == 5'd0);
   assign data_slot   = (slot != 5'd0) && (slot <= LAST_SLOT);
   assign accept      = din_valid && !hold_full;
   assign din_ready   = !hold_full;

   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         mclk       <= 1'b0;
         sclk       <= 1'b0;
         lrck       <= 1'b0;
         frame_tick <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         cnt        <= cnt + 11'd1;
         mclk       <= cnt[1];
         sclk       <= cnt[4];
         lrck       <= cnt[10];
         frame_tick <= frame_start;
         underrun   <= frame_start && !hold_full;
      end
   end

   // A frame start with an empty holding register may still capture a pair;
   // that pair then plays in the following frame.
   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) begin
         hold_full <= 1'b0;
         hold_l    <= '0;
         hold_r    <= '0;
      end else if (frame_start && hold_full) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_full <= 1'b1;
         hold_l    <= din_l;
         hold_r    <= din_r;
      end
   end

   // sdata is registered at slot boundaries so it lines up with the
   // registered sclk falling edge.
   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) begin
         shift_l <= '0;
         shift_r <= '0;
         sdata   <= 1'b0;
      end else if (frame_start) begin
         shift_l <= hold_full ? hold_l : '0;
         shift_r <= hold_full ? hold_r : '0;
      end else if (slot_start) begin
         if (!data_slot) begin
            sdata <= 1'b0;
         end else if (cnt[10]) begin
            sdata   <= shift_r[WIDTH-1];
            shift_r <= {shift_r[WIDTH-2:0], 1'b0};
         end else begin
            sdata   <= shift_l[WIDTH-1];
            shift_l <= {shift_l[WIDTH-2:0], 1'b0};
         end
      end
   end
endmodule
`default_nettype wire
